snake_score_counter: RTL and testbench
======================================

Name: snake_score_counter

Overview:
- Produces the game score consumed by the master game state machine, which compares it against the win value.
- Consumes that machine's 2-bit game state and the snake-logic apple-eaten signal.
- Counts rising edges of the eat signal only during play and freezes the count at game over.
- Clears the count when idle; emits a one-cycle point pulse for growth and sound logic.

Parameters:
- WIDTH, 4, width of the score and high-score outputs.
- WIN_SCORE, 10, saturation value of the score; must be ≤ 2^WIDTH−1.

Ports:
- CLOCK  in  1  system clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- STATE_IN  in  2  game state: 00 idle, 01 play, 10 game over, 11 illegal.
- APPLE_EATEN  in  1  synchronous level from snake logic; may stay high for several cycles per apple.
- SCORE_OUT  out  WIDTH  current score, registered.
- POINT_PULSE  out  1  one-cycle pulse per accepted point, registered.
- HIGH_SCORE_OUT  out  WIDTH  best final score since reset; see Optional Feature.

Behaviour:
- Reset (RESET_N low, asynchronous assert; release takes effect at the next CLOCK edge):
  - SCORE_OUT=0, POINT_PULSE=0, HIGH_SCORE_OUT=0.
  - eat_d=1, which blocks a spurious edge if APPLE_EATEN is high at release.
- Edge detect: eat_d <= APPLE_EATEN every cycle; rise = APPLE_EATEN & ~eat_d.
- Mode is decoded from STATE_IN as sampled at each edge; there is no internal copy of the game FSM.
  - 00 or 11 (CLEAR): SCORE_OUT <= 0, POINT_PULSE <= 0. Edge detector still tracks APPLE_EATEN.
  - 01 (COUNT): if rise and SCORE_OUT < WIN_SCORE, then SCORE_OUT <= SCORE_OUT+1 and POINT_PULSE <= 1. Otherwise SCORE_OUT holds and POINT_PULSE <= 0.
  - 10 (HOLD): SCORE_OUT holds; rise is ignored; POINT_PULSE <= 0.
- Latency:
  - APPLE_EATEN rises before edge k → SCORE_OUT and POINT_PULSE change after edge k and are visible in cycle k+1.
  - POINT_PULSE is high for exactly one cycle.
- Saturation: at SCORE_OUT==WIN_SCORE, further rises in COUNT do nothing (no wrap, no pulse).
- Held eat level: a multi-cycle APPLE_EATEN counts once; it must fall and rise again to count again.
- Simultaneous events: a rise on the same edge that STATE_IN first reads 10 is not counted; a rise on the same edge that STATE_IN first reads 01 is counted.
- Idle→play clears the score by construction, because idle held SCORE_OUT at 0.
- Arithmetic is unsigned WIDTH-bit; the increment never exceeds WIN_SCORE.
- Reset mid-game: all outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro SNAKE_SCORE_HIGH_SCORE_EN.
- Defined:
  - On any edge with STATE_IN==10 and SCORE_OUT > HIGH_SCORE_OUT: HIGH_SCORE_OUT <= SCORE_OUT.
  - Value survives CLEAR and new games; cleared only by RESET_N.
  - Visible one cycle after the first HOLD edge.
- Undefined: HIGH_SCORE_OUT is constant 0; no register is inferred.

Test Plan:
- Reset, STATE_IN=01, three single-cycle APPLE_EATEN pulses → SCORE_OUT 1,2,3, each one cycle after its pulse; three POINT_PULSEs of one cycle each.
- STATE_IN=01, APPLE_EATEN held high for 5 cycles → SCORE_OUT +1 only, one POINT_PULSE.
- STATE_IN=01, 12 pulses → SCORE_OUT stops at 10; pulses 11 and 12 give no POINT_PULSE.
- Score 4, STATE_IN→10 on the same edge as an APPLE_EATEN rise → SCORE_OUT stays 4; later pulses ignored; STATE_IN→00 → SCORE_OUT=0 next cycle.
- APPLE_EATEN high while RESET_N released, STATE_IN=01 → no increment until APPLE_EATEN falls then rises. RESET_N low mid-count at score 6 → SCORE_OUT=0 without a clock edge.
- With SNAKE_SCORE_HIGH_SCORE_EN:
  - game ends at 7 → HIGH_SCORE_OUT=7.
  - idle, then game ends at 3 → HIGH_SCORE_OUT stays 7.
  - Without the macro → HIGH_SCORE_OUT=0 throughout.

Source files
------------

// File: rtl/snake_score_counter.sv
// Game score counter: counts apple-eaten rising edges in play, freezes in game over, clears in idle.
// Latency: one cycle from eat rise to SCORE_OUT/POINT_PULSE. No backpressure; every input sampled each edge.
// Optional best-final-score tracking on HIGH_SCORE_OUT when SNAKE_SCORE_HIGH_SCORE_EN is defined.
module snake_score_counter #(
    parameter int WIDTH     = 4,
    parameter int WIN_SCORE = 10
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic [1:0]       STATE_IN,
    input  logic             APPLE_EATEN,
    output logic [WIDTH-1:0] SCORE_OUT,
    output logic             POINT_PULSE,
    output logic [WIDTH-1:0] HIGH_SCORE_OUT
);

    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [1:0] ST_OVER = 2'b10;
    localparam logic [WIDTH-1:0] WIN = WIDTH'(WIN_SCORE);

    logic [WIDTH-1:0] score_q, score_d;
    logic             pulse_q, pulse_d;
    logic             eat_q;
    logic             rise;

    assign rise = APPLE_EATEN & ~eat_q;

    always_comb begin
        score_d = score_q;
        pulse_d = 1'b0;
        case (STATE_IN)
            ST_PLAY: begin
                if (rise && (score_q < WIN)) begin
                    score_d = score_q + WIDTH'(1);
                    pulse_d = 1'b1;
                end
            end
            ST_OVER: score_d = score_q;
            default: score_d = '0;
        endcase
    end

    // eat_q resets high so an eat level already present at release is not a rise.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            score_q <= '0;
            pulse_q <= 1'b0;
            eat_q   <= 1'b1;
        end else begin
            score_q <= score_d;
            pulse_q <= pulse_d;
            eat_q   <= APPLE_EATEN;
        end
    end

    assign SCORE_OUT   = score_q;
    assign POINT_PULSE = pulse_q;

`ifdef SNAKE_SCORE_HIGH_SCORE_EN
    logic [WIDTH-1:0] high_q, high_d;

    always_comb begin
        high_d = high_q;
        if ((STATE_IN == ST_OVER) && (score_q > high_q)) begin
            high_d = score_q;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            high_q <= '0;
        end else begin
            high_q <= high_d;
        end
    end

    assign HIGH_SCORE_OUT = high_q;
`else
    assign HIGH_SCORE_OUT = '0;
`endif

endmodule

// File: tb/tb_snake_score_counter.sv
// Directed plus randomized checks of snake_score_counter against a game-rule reference model.
module tb_snake_score_counter;

    logic       CLOCK;
    logic       RESET_N;
    logic [1:0] STATE_IN;
    logic       APPLE_EATEN;
    logic [3:0] SCORE_OUT;
    logic       POINT_PULSE;
    logic [3:0] HIGH_SCORE_OUT;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: score, last pulse, previous eat level, best final score.
    int m_score, m_pulse, m_prev, m_high;
    int pulse_cnt;
`ifdef SNAKE_SCORE_HIGH_SCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    snake_score_counter #(.WIDTH(4), .WIN_SCORE(10)) dut (
        .CLOCK          (CLOCK),
        .RESET_N        (RESET_N),
        .STATE_IN       (STATE_IN),
        .APPLE_EATEN    (APPLE_EATEN),
        .SCORE_OUT      (SCORE_OUT),
        .POINT_PULSE    (POINT_PULSE),
        .HIGH_SCORE_OUT (HIGH_SCORE_OUT)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_score = 0;
        m_pulse = 0;
        m_prev  = 1;
        m_high  = 0;
    endtask

    // Game rules: a point is an eat level going 0->1 during play, capped at the win score.
    task automatic model_edge(input int st, input int eat);
        bit new_apple;
        new_apple = (eat == 1) && (m_prev == 0);
        if (HS_EN && st == 2 && m_score > m_high) m_high = m_score;
        m_pulse = 0;
        if (st == 1) begin
            if (new_apple && m_score < 10) begin
                m_score = m_score + 1;
                m_pulse = 1;
            end
        end else if (st != 2) begin
            m_score = 0;
        end
        m_prev = eat;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_score"}, SCORE_OUT, m_score);
        chk({tag, "_pulse"}, POINT_PULSE, m_pulse);
        chk({tag, "_high"}, HIGH_SCORE_OUT, m_high);
    endtask

    task automatic cycle(input logic [1:0] st, input logic eat, input string tag);
        @(negedge CLOCK);
        STATE_IN    = st;
        APPLE_EATEN = eat;
        @(posedge CLOCK);
        if (RESET_N) model_edge(int'(st), int'(eat));
        #1;
        if (POINT_PULSE === 1'b1) pulse_cnt++;
        check_all(tag);
    endtask

    task automatic apples(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            cycle(2'b01, 1'b1, tag);
            cycle(2'b01, 1'b0, tag);
        end
    endtask

    initial begin
        RESET_N     = 1'b0;
        STATE_IN    = 2'b00;
        APPLE_EATEN = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge CLOCK);
        RESET_N = 1'b1;
        cycle(2'b01, 1'b0, "idle_play");

        // Three single-cycle apples: each shows one cycle after its pulse.
        for (int k = 1; k <= 3; k++) begin
            cycle(2'b01, 1'b1, "tp1_rise");
            chk("tp1_score_const", SCORE_OUT, k);
            chk("tp1_pulse_hi", POINT_PULSE, 1);
            cycle(2'b01, 1'b0, "tp1_fall");
            chk("tp1_pulse_lo", POINT_PULSE, 0);
        end

        // Held eat level counts once.
        pulse_cnt = 0;
        for (int i = 0; i < 5; i++) cycle(2'b01, 1'b1, "tp2_held");
        cycle(2'b01, 1'b0, "tp2_fall");
        chk("tp2_score_const", SCORE_OUT, 4);
        chk("tp2_pulse_cnt", pulse_cnt, 1);

        // Saturation at the win score.
        cycle(2'b00, 1'b0, "tp3_clear");
        pulse_cnt = 0;
        apples(12, "tp3_sat");
        chk("tp3_score_const", SCORE_OUT, 10);
        chk("tp3_pulse_cnt", pulse_cnt, 10);

        // Rise on the first play edge counts; rise on the first game-over edge does not.
        cycle(2'b00, 1'b0, "tp4_clear");
        cycle(2'b01, 1'b1, "tp4_first_play");
        chk("tp4_first_play_const", SCORE_OUT, 1);
        cycle(2'b01, 1'b0, "tp4_fall");
        apples(3, "tp4_to4");
        cycle(2'b10, 1'b1, "tp4_over_rise");
        chk("tp4_hold_const", SCORE_OUT, 4);
        cycle(2'b10, 1'b0, "tp4_hold");
        cycle(2'b10, 1'b1, "tp4_hold_rise");
        chk("tp4_hold_ignored", SCORE_OUT, 4);
        cycle(2'b00, 1'b0, "tp4_idle");
        chk("tp4_idle_const", SCORE_OUT, 0);

        // High score: game ending at 7, then a worse game ending at 3.
        apples(7, "hs_to7");
        cycle(2'b10, 1'b0, "hs_over7");
        cycle(2'b10, 1'b0, "hs_over7b");
        chk("hs_seven", HIGH_SCORE_OUT, HS_EN ? 7 : 0);
        cycle(2'b00, 1'b0, "hs_idle");
        cycle(2'b11, 1'b0, "hs_illegal");
        apples(3, "hs_to3");
        cycle(2'b10, 1'b0, "hs_over3");
        cycle(2'b10, 1'b0, "hs_over3b");
        chk("hs_keep7", HIGH_SCORE_OUT, HS_EN ? 7 : 0);

        // Eat high across reset release must not count until it falls and rises.
        @(negedge CLOCK);
        RESET_N     = 1'b0;
        APPLE_EATEN = 1'b1;
        STATE_IN    = 2'b01;
        model_reset();
        #1;
        check_all("rst_eat");
        @(negedge CLOCK);
        RESET_N = 1'b1;
        for (int i = 0; i < 3; i++) cycle(2'b01, 1'b1, "rel_held");
        chk("rel_no_count", SCORE_OUT, 0);
        cycle(2'b01, 1'b0, "rel_fall");
        cycle(2'b01, 1'b1, "rel_rise");
        chk("rel_count", SCORE_OUT, 1);
        cycle(2'b01, 1'b0, "rel_fall2");

        // Asynchronous reset mid-count at 6.
        apples(5, "mid_to6");
        chk("mid_six", SCORE_OUT, 6);
        @(negedge CLOCK);
        #2;
        RESET_N = 1'b0;
        model_reset();
        #1;
        chk("async_rst_score", SCORE_OUT, 0);
        chk("async_rst_pulse", POINT_PULSE, 0);
        chk("async_rst_high", HIGH_SCORE_OUT, 0);
        @(negedge CLOCK);
        RESET_N = 1'b1;

        // Randomized games.
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [1:0] st;
            logic eat;
            r = int'($urandom_range(0, 19));
            if (r < 13)      st = 2'b01;
            else if (r < 17) st = 2'b10;
            else if (r < 19) st = 2'b00;
            else             st = 2'b11;
            eat = ($urandom_range(0, 2) == 0) ? ~APPLE_EATEN : APPLE_EATEN;
            cycle(st, eat, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
